// File: rtl/ili9341_window_seq.sv
// ----------------------------------------------------------------------------
// ili9341_window_seq
//
// Opens a drawing window on an ILI9341 TFT controller and then streams the
// RGB565 pixels that fill it. One request produces this byte sequence:
//   0x2A, x0 hi, x0 lo, x1 hi, x1 lo,     (column address set)
//   0x2B, y0 hi, y0 lo, y1 hi, y1 lo,     (page address set)
//   0x2C,                                 (memory write)
//   then {pixel[15:8], pixel[7:0]} for every pixel of the window.
// Every byte goes out over a Wishbone-style strobe/ack byte port, and tft_dc_o
// marks it as a command (0) or as data (1).
//
// Ports
//   CLK_I, RST_I           clock (rising edge) and synchronous active-high reset
//   win_req_i              start a window; only sampled while idle
//   x0_i, x1_i, y0_i, y1_i inclusive column and row bounds of the window
//   win_busy_o             a window sequence is in progress
//   win_err_o              one-cycle pulse when a request is rejected
//   pix_valid_i/_data_i    pixel stream input (RGB565)
//   pix_ready_o            a pixel can be taken this cycle
//   spi_stb_o, spi_we_o    byte request to the SPI master
//   spi_dat_o, tft_dc_o    byte to send and its command/data flag
//   spi_ack_i, spi_rty_i   byte accepted / master busy (retry)
//   done_o                 one-cycle pulse once the last pixel byte is accepted
//
// Build option
//   ILI9341_SEQ_BOUNDS_CHECK_EN  when defined, a request whose bounds are
//   reversed or beyond MAX_X/MAX_Y is rejected with win_err_o and sends
//   nothing. When undefined, bounds are used as given and the pixel counters
//   wrap modulo 9 bits.
// ----------------------------------------------------------------------------
module ili9341_window_seq #(
   parameter int MAX_X = 239,
   parameter int MAX_Y = 319
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        win_req_i,
   input  logic [8:0]  x0_i,
   input  logic [8:0]  x1_i,
   input  logic [8:0]  y0_i,
   input  logic [8:0]  y1_i,
   output logic        win_busy_o,
   output logic        win_err_o,
   input  logic        pix_valid_i,
   input  logic [15:0] pix_data_i,
   output logic        pix_ready_o,
   output logic        spi_stb_o,
   output logic        spi_we_o,
   output logic [7:0]  spi_dat_o,
   input  logic        spi_ack_i,
   input  logic        spi_rty_i,
   output logic        tft_dc_o,
   output logic        done_o
);

   typedef enum logic [3:0] {
      IDLE, CASET, CASET_P, PASET, PASET_P, RAMWR, PIX_HI, PIX_LO, DONE
   } stateT;

   stateT       stateQ, stateD;

   logic [8:0]  x0Q, x1Q, y0Q, y1Q;
   logic [8:0]  colQ, rowQ;
   logic [1:0]  paramQ;     // which of the four coordinate bytes is next
   logic        gapQ;       // forces one idle strobe cycle after each byte
   logic        pixHaveQ;   // a pixel is held in pixQ waiting to be sent
   logic [15:0] pixQ;

   logic        boundsOk;
   logic        startWin;
   logic        inByte;
   logic        xfer;
   logic        lastPix;
   logic        pixTake;

   // ---------------------------------------------------------------------
   // Request qualification
   // ---------------------------------------------------------------------
`ifdef ILI9341_SEQ_BOUNDS_CHECK_EN
   localparam logic [8:0] LastCol = 9'(MAX_X);
   localparam logic [8:0] LastRow = 9'(MAX_Y);

   logic errQ;

   assign boundsOk = (x1_i >= x0_i) && (y1_i >= y0_i) &&
                     (x1_i <= LastCol) && (y1_i <= LastRow);

   // A rejected request leaves the FSM in IDLE; only this pulse reports it.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         errQ <= 1'b0;
      end else begin
         errQ <= (stateQ == IDLE) && win_req_i && !boundsOk;
      end
   end

   assign win_err_o = errQ;
`else
   assign boundsOk  = 1'b1;
   assign win_err_o = 1'b0;

   // Without the check the limits only have to fit the 9-bit coordinates.
   if (MAX_X > 511 || MAX_Y > 511) begin : g_limitWiderThanPorts
   end
`endif

   assign startWin = (stateQ == IDLE) && win_req_i && boundsOk;

   // ---------------------------------------------------------------------
   // Byte handshake
   // ---------------------------------------------------------------------
   assign inByte = (stateQ == CASET)  || (stateQ == CASET_P) ||
                   (stateQ == PASET)  || (stateQ == PASET_P) ||
                   (stateQ == RAMWR)  || (stateQ == PIX_HI)  ||
                   (stateQ == PIX_LO);

   // In PIX_HI there is nothing to send until a pixel has been captured.
   assign spi_stb_o = inByte && !gapQ && ((stateQ != PIX_HI) || pixHaveQ);
   assign spi_we_o  = spi_stb_o;

   // A retry from the master cancels an ack in the same cycle.
   assign xfer = spi_stb_o && spi_ack_i && !spi_rty_i;

   assign lastPix = (colQ == x1Q) && (rowQ == y1Q);
   assign pixTake = pix_valid_i && pix_ready_o;

   function automatic logic [7:0] coordByte(input logic [8:0] first,
                                            input logic [8:0] last,
                                            input logic [1:0] idx);
      case (idx)
         2'd0:    coordByte = {7'd0, first[8]};
         2'd1:    coordByte = first[7:0];
         2'd2:    coordByte = {7'd0, last[8]};
         default: coordByte = last[7:0];
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   // NOTE: every clocked register uses <= so all flops update from values
   // sampled at the same edge, independent of statement order.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and decoded outputs
   // ---------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      stateD      = stateQ;
      spi_dat_o   = 8'h00;
      tft_dc_o    = 1'b0;
      pix_ready_o = 1'b0;
      win_busy_o  = 1'b1;
      done_o      = 1'b0;

      case (stateQ)
         IDLE: begin
            win_busy_o = 1'b0;
            if (startWin) stateD = CASET;
         end
         CASET: begin
            spi_dat_o = 8'h2A;
            if (xfer) stateD = CASET_P;
         end
         CASET_P: begin
            spi_dat_o = coordByte(x0Q, x1Q, paramQ);
            tft_dc_o  = 1'b1;
            if (xfer && (paramQ == 2'd3)) stateD = PASET;
         end
         PASET: begin
            spi_dat_o = 8'h2B;
            if (xfer) stateD = PASET_P;
         end
         PASET_P: begin
            spi_dat_o = coordByte(y0Q, y1Q, paramQ);
            tft_dc_o  = 1'b1;
            if (xfer && (paramQ == 2'd3)) stateD = RAMWR;
         end
         RAMWR: begin
            spi_dat_o = 8'h2C;
            if (xfer) stateD = PIX_HI;
         end
         PIX_HI: begin
            spi_dat_o   = pixQ[15:8];
            tft_dc_o    = 1'b1;
            pix_ready_o = !pixHaveQ;
            if (xfer) stateD = PIX_LO;
         end
         PIX_LO: begin
            spi_dat_o = pixQ[7:0];
            tft_dc_o  = 1'b1;
            if (xfer) stateD = lastPix ? DONE : PIX_HI;
         end
         DONE: begin
            done_o = 1'b1;
            stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Window bounds, pixel counters and pixel holding register
   // ---------------------------------------------------------------------
   // NOTE: the bounds, counters and pixel register are plain flops rather
   // than a memory, so they are cleared by reset like the rest of the state.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         x0Q      <= 9'd0;
         x1Q      <= 9'd0;
         y0Q      <= 9'd0;
         y1Q      <= 9'd0;
         colQ     <= 9'd0;
         rowQ     <= 9'd0;
         paramQ   <= 2'd0;
         gapQ     <= 1'b0;
         pixHaveQ <= 1'b0;
         pixQ     <= 16'h0000;
      end else begin
         gapQ <= xfer;

         if (startWin) begin
            x0Q      <= x0_i;
            x1Q      <= x1_i;
            y0Q      <= y0_i;
            y1Q      <= y1_i;
            colQ     <= x0_i;
            rowQ     <= y0_i;
            paramQ   <= 2'd0;
            pixHaveQ <= 1'b0;
         end

         // Wraps 3 -> 0 on the last coordinate byte, ready for the next set.
         if (xfer && ((stateQ == CASET_P) || (stateQ == PASET_P))) begin
            paramQ <= paramQ + 2'd1;
         end

         if (pixTake) begin
            pixQ     <= pix_data_i;
            pixHaveQ <= 1'b1;
         end

         // Column/row scan replaces a width*height product.
         if (xfer && (stateQ == PIX_LO)) begin
            pixHaveQ <= 1'b0;
            if (!lastPix) begin
               if (colQ == x1Q) begin
                  colQ <= x0Q;
                  rowQ <= rowQ + 9'd1;
               end else begin
                  colQ <= colQ + 9'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ili9341_window_seq.sv
// ----------------------------------------------------------------------------
// tb_ili9341_window_seq
//
// Directed bench for ili9341_window_seq. For each window the bench builds the
// byte list the display must receive (command, coordinate bytes, pixel bytes)
// and a monitor compares every accepted byte against it. An SPI responder
// acks two cycles after each strobe; a feeder presents pixels from a queue.
// Literal byte tables pin the generated lists for the reference windows.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ili9341_window_seq;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b1;
   logic        win_req_i = 1'b0;
   logic [8:0]  x0_i = '0, x1_i = '0, y0_i = '0, y1_i = '0;
   logic        win_busy_o, win_err_o;
   logic        pix_valid_i = 1'b0;
   logic [15:0] pix_data_i = '0;
   logic        pix_ready_o;
   logic        spi_stb_o, spi_we_o;
   logic [7:0]  spi_dat_o;
   logic        spi_ack_i = 1'b0, spi_rty_i = 1'b0;
   logic        tft_dc_o, done_o;

   ili9341_window_seq #(.MAX_X(239), .MAX_Y(319)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .win_req_i(win_req_i), .x0_i(x0_i), .x1_i(x1_i), .y0_i(y0_i), .y1_i(y1_i),
      .win_busy_o(win_busy_o), .win_err_o(win_err_o),
      .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
      .spi_stb_o(spi_stb_o), .spi_we_o(spi_we_o), .spi_dat_o(spi_dat_o),
      .spi_ack_i(spi_ack_i), .spi_rty_i(spi_rty_i),
      .tft_dc_o(tft_dc_o), .done_o(done_o)
   );

   always #5 CLK_I = ~CLK_I;

   int          checks = 0;
   int          fails  = 0;
   logic [8:0]  expQ[$];    // {dc, byte} still owed by the DUT
   logic [8:0]  gotQ[$];    // {dc, byte} accepted in the current window
   logic [15:0] pixQ[$];    // pixels not yet taken by the DUT
   int          capCount = 0;
   int          popCount = 0;
   int          doneCount = 0;
   bit          pixHold = 1'b0;
   int          ackCnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK_I);
         #1;
      end
   endtask

   // SPI master model: ack on the second cycle of each strobe.
   initial forever begin
      @(posedge CLK_I);
      #1;
      if (spi_stb_o === 1'b1) ackCnt++;
      else                    ackCnt = 0;
      spi_ack_i = (ackCnt >= 2);
   end

   // Pixel feeder: drop pixels the DUT has taken, present the next one.
   initial forever begin
      @(posedge CLK_I);
      #1;
      while (popCount < capCount && pixQ.size() > 0) begin
         void'(pixQ.pop_front());
         popCount++;
      end
      popCount    = capCount;
      pix_valid_i = (pixQ.size() > 0) && !pixHold;
      pix_data_i  = (pixQ.size() > 0) ? pixQ[0] : 16'h0000;
   end

   // Compare process: samples mid-cycle, i.e. what the DUT sees at the next edge.
   logic       prevStb = 1'b0, prevXfer = 1'b0, prevDone = 1'b0;
   logic [8:0] prevByte = '0;
   logic       monXfer;
   initial forever begin
      @(negedge CLK_I);
      monXfer = (spi_stb_o === 1'b1) && spi_ack_i && !spi_rty_i;
      if (spi_stb_o === 1'b1) begin
         check("we_with_stb", spi_we_o, 1'b1);
         check("busy_with_stb", win_busy_o, 1'b1);
         check("no_ready_while_byte", pix_ready_o, 1'b0);
         check("stb_gap_after_byte", prevXfer, 1'b0);
         if (prevStb && !prevXfer) check("byte_stable", {tft_dc_o, spi_dat_o}, prevByte);
      end
      if (monXfer) begin
         gotQ.push_back({tft_dc_o, spi_dat_o});
         check("byte_expected", expQ.size() > 0, 1'b1);
         if (expQ.size() > 0) check("spi_byte", {tft_dc_o, spi_dat_o}, expQ.pop_front());
      end
      if (pix_valid_i && pix_ready_o === 1'b1) capCount++;
      if (done_o === 1'b1) begin
         doneCount++;
         check("done_after_last_byte", expQ.size(), 0);
         check("done_one_cycle", prevDone, 1'b0);
      end
`ifndef ILI9341_SEQ_BOUNDS_CHECK_EN
      if (win_req_i) check("err_tied_low", win_err_o, 1'b0);
`endif
      prevStb  = (spi_stb_o === 1'b1);
      prevXfer = monXfer;
      prevDone = (done_o === 1'b1);
      prevByte = {tft_dc_o, spi_dat_o};
   end

   // Builds the byte list the display must see and issues the request.
   task automatic startWindow(input logic [8:0] x0, input logic [8:0] x1,
                              input logic [8:0] y0, input logic [8:0] y1,
                              input logic [15:0] firstPix);
      int          nPix;
      logic [15:0] p;
      gotQ.delete();
      expQ.push_back({1'b0, 8'h2A});
      expQ.push_back({1'b1, 7'd0, x0[8]}); expQ.push_back({1'b1, x0[7:0]});
      expQ.push_back({1'b1, 7'd0, x1[8]}); expQ.push_back({1'b1, x1[7:0]});
      expQ.push_back({1'b0, 8'h2B});
      expQ.push_back({1'b1, 7'd0, y0[8]}); expQ.push_back({1'b1, y0[7:0]});
      expQ.push_back({1'b1, 7'd0, y1[8]}); expQ.push_back({1'b1, y1[7:0]});
      expQ.push_back({1'b0, 8'h2C});
      nPix = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
      for (int i = 0; i < nPix; i++) begin
         p = (i == 0) ? firstPix : (firstPix ^ 16'(i * 16'h2F1D));
         pixQ.push_back(p);
         expQ.push_back({1'b1, p[15:8]});
         expQ.push_back({1'b1, p[7:0]});
      end
      x0_i = x0; x1_i = x1; y0_i = y0; y1_i = y1;
      win_req_i = 1'b1;
      tick();
      win_req_i = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int start = doneCount;
      int n = 0;
      while (doneCount == start && n < budget) begin
         tick();
         n++;
      end
      check(name, doneCount - start, 1);
   endtask

   task automatic waitBytes(input string name, input int count, input int budget);
      int n = 0;
      while (gotQ.size() < count && n < budget) begin
         tick();
         n++;
      end
      check(name, gotQ.size(), count);
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "_stb"},   spi_stb_o,   1'b0);
      check({tag, "_we"},    spi_we_o,    1'b0);
      check({tag, "_dat"},   spi_dat_o,   8'h00);
      check({tag, "_dc"},    tft_dc_o,    1'b0);
      check({tag, "_ready"}, pix_ready_o, 1'b0);
      check({tag, "_busy"},  win_busy_o,  1'b0);
      check({tag, "_err"},   win_err_o,   1'b0);
      check({tag, "_done"},  done_o,      1'b0);
   endtask

`ifdef ILI9341_SEQ_BOUNDS_CHECK_EN
   task automatic requestBad(input string tag, input logic [8:0] x0, input logic [8:0] x1,
                             input logic [8:0] y0, input logic [8:0] y1);
      int errCycles = 0, stbCycles = 0, busyCycles = 0;
      x0_i = x0; x1_i = x1; y0_i = y0; y1_i = y1;
      win_req_i = 1'b1;
      tick();
      win_req_i = 1'b0;
      repeat (10) begin
         @(negedge CLK_I);
         if (win_err_o)  errCycles++;
         if (spi_stb_o)  stbCycles++;
         if (win_busy_o) busyCycles++;
         @(posedge CLK_I);
         #1;
      end
      check({tag, "_err_pulse"}, errCycles, 1);
      check({tag, "_no_stb"}, stbCycles, 0);
      check({tag, "_stay_idle"}, busyCycles, 0);
   endtask
`endif

   logic [7:0]  lit1[13] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2B, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h2C, 8'hF8, 8'h00};
   logic [12:0] dcLit1   = 13'b0111101111011;
   logic [7:0]  caset2[4] = '{8'h00, 8'h0A, 8'h00, 8'h0B};
   logic [7:0]  paset2[4] = '{8'h00, 8'h14, 8'h00, 8'h15};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      // Reset state
      RST_I = 1'b1;
      tick(3);
      @(negedge CLK_I);
      checkResetOutputs("reset");
      tick();
      RST_I = 1'b0;
      tick(2);

      // Single-pixel window at the origin
      startWindow(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
      waitDone("w1_done", 300);
      check("w1_byte_count", gotQ.size(), 13);
      for (int i = 0; i < 13 && i < gotQ.size(); i++) begin
         check("w1_literal_byte", gotQ[i][7:0], lit1[i]);
         check("w1_literal_dc", gotQ[i][8], dcLit1[12 - i]);
      end
      @(negedge CLK_I);
      check("w1_idle_after_done", win_busy_o, 1'b0);
      tick(3);

      // 2x2 window; a second request while busy must be ignored
      startWindow(9'd10, 9'd11, 9'd20, 9'd21, 16'h1234);
      x0_i = 9'd100; x1_i = 9'd200; y0_i = 9'd7; y1_i = 9'd9;
      win_req_i = 1'b1;
      @(negedge CLK_I);
      check("w2_busy", win_busy_o, 1'b1);
      @(posedge CLK_I);
      #1;
      win_req_i = 1'b0;
      waitDone("w2_done", 500);
      check("w2_byte_count", gotQ.size(), 19);
      if (gotQ.size() >= 10) begin
         for (int i = 0; i < 4; i++) begin
            check("w2_caset_param", gotQ[1 + i][7:0], caset2[i]);
            check("w2_paset_param", gotQ[6 + i][7:0], paset2[i]);
         end
      end
      check("w2_done_total", doneCount, 2);
      tick(3);

      // Retry held for five cycles over byte 3
      startWindow(9'd0, 9'd0, 9'd0, 9'd0, 16'h07E0);
      begin
         int n = 0;
         while (!(gotQ.size() == 2 && spi_stb_o === 1'b1) && n < 100) begin
            tick();
            n++;
         end
         check("rty_reach_byte3", gotQ.size(), 2);
      end
      spi_rty_i = 1'b1;
      repeat (5) begin
         @(negedge CLK_I);
         check("rty_dat_held", spi_dat_o, 8'h00);
         check("rty_stb_held", spi_stb_o, 1'b1);
         check("rty_not_counted", gotQ.size(), 2);
         @(posedge CLK_I);
         #1;
      end
      spi_rty_i = 1'b0;
      waitDone("rty_done", 300);
      check("rty_byte_count", gotQ.size(), 13);
      tick(3);

      // Pixel source stalls for ten cycles between pixels
      startWindow(9'd0, 9'd2, 9'd0, 9'd0, 16'hABCD);
      waitBytes("stall_reach_pix1_hi", 12, 300);
      pixHold = 1'b1;
      waitBytes("stall_reach_pix1_lo", 13, 100);
      repeat (10) begin
         @(negedge CLK_I);
         check("stall_no_stb", spi_stb_o, 1'b0);
         check("stall_ready", pix_ready_o, 1'b1);
         @(posedge CLK_I);
         #1;
      end
      pixHold = 1'b0;
      waitDone("stall_done", 300);
      check("stall_byte_count", gotQ.size(), 17);
      tick(3);

      // Reset during PIX_LO, then a clean restart
      startWindow(9'd0, 9'd1, 9'd0, 9'd0, 16'h5555);
      waitBytes("rst_reach_pix_lo", 12, 300);
      RST_I = 1'b1;
      @(posedge CLK_I);
      #1;
      RST_I = 1'b0;
      @(negedge CLK_I);
      checkResetOutputs("midrst");
      @(posedge CLK_I);
      #1;
      expQ.delete();
      pixQ.delete();
      tick(2);
      startWindow(9'd0, 9'd0, 9'd0, 9'd0, 16'h001F);
      waitDone("rst_restart_done", 300);
      check("rst_restart_count", gotQ.size(), 13);
      if (gotQ.size() > 0) check("rst_restart_first", gotQ[0], 9'h02A);
      tick(3);

`ifdef ILI9341_SEQ_BOUNDS_CHECK_EN
      requestBad("bad_x_reversed", 9'd5, 9'd4, 9'd0, 9'd0);
      requestBad("bad_x_max", 9'd0, 9'd240, 9'd0, 9'd0);
      requestBad("bad_y_max", 9'd0, 9'd0, 9'd0, 9'd320);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
